// File: rtl/riscv_mem_arb.sv
// Fetch/data arbiter for a single-port pipelined unified memory.
// Read responses are steered back to their owning port by a tag shift register.
module riscv_mem_arb #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_if_req,
   input  logic [XLEN-1:0] i_if_addr,
   input  logic            i_if_flush,
   output logic            o_if_gnt,
   output logic            o_if_rvalid,
   output logic [XLEN-1:0] o_if_rdata,
   input  logic            i_dm_req,
   input  logic            i_dm_wr_en,
   input  logic [XLEN-1:0] i_dm_addr,
   input  logic [XLEN-1:0] i_dm_wdata,
   input  logic [3:0]      i_dm_bsel,
   output logic            o_dm_gnt,
   output logic            o_dm_rvalid,
   output logic [XLEN-1:0] o_dm_rdata,
   output logic            o_mem_en,
   output logic            o_mem_wr_en,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_wdata,
   output logic [3:0]      o_mem_bsel,
   input  logic [XLEN-1:0] i_mem_rdata
);

   logic [3:0]      starve_cnt_q, starve_cnt_d;
   logic [MEM_LAT:0] tag_vld_q, tag_vld_d;
   logic [MEM_LAT:0] tag_own_q, tag_own_d;

   logic            mem_en_q, mem_wr_en_q;
   logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
   logic [3:0]      mem_bsel_q;
   logic            if_rvalid_q, dm_rvalid_q;
   logic [XLEN-1:0] if_rdata_q, dm_rdata_q;

   logic starve, if_gnt, dm_gnt;
   logic resp_vld, if_resp, dm_resp;

   assign starve = (starve_cnt_q == 4'(STARVE_MAX));
   assign if_gnt = ~i_rst & i_if_req & ~i_if_flush & (~i_dm_req | starve);
   assign dm_gnt = ~i_rst & i_dm_req & ~if_gnt;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (~i_if_req | i_if_flush | if_gnt) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q < 4'(STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   // Flush kills every IF-owned tag as it shifts, including the one leaving the last stage.
   always_comb begin
      tag_vld_d[0] = if_gnt | (dm_gnt & ~i_dm_wr_en);
      tag_own_d[0] = dm_gnt;
      for (int i = 1; i <= int'(MEM_LAT); i++) begin
         tag_vld_d[i] = tag_vld_q[i-1] & ~(i_if_flush & ~tag_own_q[i-1]);
         tag_own_d[i] = tag_own_q[i-1];
      end
   end

   assign resp_vld = tag_vld_q[MEM_LAT] & ~(i_if_flush & ~tag_own_q[MEM_LAT]);
   assign if_resp  = resp_vld & ~tag_own_q[MEM_LAT];
   assign dm_resp  = resp_vld & tag_own_q[MEM_LAT];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         starve_cnt_q <= '0;
         tag_vld_q    <= '0;
         tag_own_q    <= '0;
         mem_en_q     <= 1'b0;
         mem_wr_en_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_bsel_q   <= '0;
         if_rvalid_q  <= 1'b0;
         if_rdata_q   <= '0;
         dm_rvalid_q  <= 1'b0;
         dm_rdata_q   <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         tag_vld_q    <= tag_vld_d;
         tag_own_q    <= tag_own_d;
         mem_en_q     <= if_gnt | dm_gnt;
         if (if_gnt) begin
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= i_if_addr;
            mem_wdata_q <= '0;
            mem_bsel_q  <= '0;
         end else if (dm_gnt) begin
            mem_wr_en_q <= i_dm_wr_en;
            mem_addr_q  <= i_dm_addr;
            mem_wdata_q <= i_dm_wdata;
            mem_bsel_q  <= i_dm_bsel;
         end
         if_rvalid_q <= if_resp;
         dm_rvalid_q <= dm_resp;
         if (if_resp) if_rdata_q <= i_mem_rdata;
         if (dm_resp) dm_rdata_q <= i_mem_rdata;
      end
   end

   assign o_if_gnt    = if_gnt;
   assign o_dm_gnt    = dm_gnt;
   assign o_if_rvalid = if_rvalid_q;
   assign o_if_rdata  = if_rdata_q;
   assign o_dm_rvalid = dm_rvalid_q;
   assign o_dm_rdata  = dm_rdata_q;
   assign o_mem_en    = mem_en_q;
   assign o_mem_wr_en = mem_wr_en_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_mem_bsel  = mem_bsel_q;

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Directed bench for riscv_mem_arb: cycle tables plus hand-written store/fetch/reset sequences.
module tb_riscv_mem_arb;
   localparam int unsigned XLEN    = 32;
   localparam int unsigned MEM_LAT = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            if_req, if_flush, dm_req, dm_wr_en;
   logic [XLEN-1:0] if_addr, dm_addr, dm_wdata;
   logic [3:0]      dm_bsel;
   logic            if_gnt, dm_gnt, if_rvalid, dm_rvalid;
   logic [XLEN-1:0] if_rdata, dm_rdata;
   logic            mem_en, mem_wr_en;
   logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]      mem_bsel;
   logic [XLEN-1:0] hist [MEM_LAT];

   int n_checks = 0;
   int n_pass   = 0;

   riscv_mem_arb #(.XLEN(XLEN), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
      .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
      .i_dm_req(dm_req), .i_dm_wr_en(dm_wr_en), .i_dm_addr(dm_addr),
      .i_dm_wdata(dm_wdata), .i_dm_bsel(dm_bsel),
      .o_dm_gnt(dm_gnt), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
      .o_mem_en(mem_en), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_bsel(mem_bsel), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] mem_fn(input logic [XLEN-1:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory model: data for the command seen in cycle c appears in cycle c+MEM_LAT.
   always @(posedge clk) begin
      hist[0] <= mem_addr;
      for (int k = 1; k < int'(MEM_LAT); k++) hist[k] <= hist[k-1];
   end
   assign mem_rdata = mem_fn(hist[MEM_LAT-1]);

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic no_rvalid(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         #1;
         chk("quiet_if_rvalid", if_rvalid, 0);
         chk("quiet_dm_rvalid", dm_rvalid, 0);
      end
   endtask

   typedef struct {
      logic if_req, dm_req, dm_wr, flush;
      logic e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(input logic a, b, c, d, e, f, g, h);
      vec_t v;
      v = '{a, b, c, d, e, f, g, h};
      vecs.push_back(v);
   endfunction

   initial begin
      // starvation: loads vs fetches, both held high (rows 0-13)
      for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 0, 1, 0, 0);
      add(1, 1, 0, 0, 1, 0, 0, 1);
      add(1, 1, 0, 0, 0, 1, 0, 1);
      add(1, 1, 0, 0, 0, 1, 0, 1);
      add(1, 1, 0, 0, 0, 1, 0, 1);
      add(1, 1, 0, 0, 0, 1, 1, 0);
      add(1, 1, 0, 0, 1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 1, 0);
      // interleaved IF/DM loads (rows 14-23)
      for (int i = 0; i < 2; i++) begin
         add(1, 0, 0, 0, 1, 0, 0, 0);
         add(0, 1, 0, 0, 0, 1, 0, 0);
      end
      add(1, 0, 0, 0, 1, 0, 1, 0);
      add(0, 1, 0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 2; i++) begin
         add(0, 0, 0, 0, 0, 0, 1, 0);
         add(0, 0, 0, 0, 0, 0, 0, 1);
      end
      // flush after three fetches, with a load granted in the flush cycle (rows 24-31)
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 1, 0, 0, 0);
      add(1, 1, 0, 1, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1);

      rst = 1'b1;
      if_req = 1'b1; if_flush = 1'b0; if_addr = 32'h40;
      dm_req = 1'b1; dm_wr_en = 1'b0; dm_addr = 32'h80; dm_wdata = '0; dm_bsel = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_dm_gnt", dm_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_dm_rvalid", dm_rvalid, 0);
      if_req = 1'b0; dm_req = 1'b0;
      rst = 1'b0;
      tick();

      // store
      tick();
      dm_req = 1'b1; dm_wr_en = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h12345678; dm_bsel = 4'h3;
      #1;
      chk("st_dm_gnt", dm_gnt, 1);
      chk("st_if_gnt", if_gnt, 0);
      tick();
      dm_req = 1'b0; dm_wr_en = 1'b0;
      #1;
      chk("st_mem_en", mem_en, 1);
      chk("st_mem_wr_en", mem_wr_en, 1);
      chk("st_mem_addr", mem_addr, 32'h2000);
      chk("st_mem_wdata", mem_wdata, 32'h12345678);
      chk("st_mem_bsel", mem_bsel, 32'h3);
      no_rvalid(6);

      // single fetch
      tick();
      if_req = 1'b1; if_addr = 32'h100;
      #1;
      chk("f_if_gnt", if_gnt, 1);
      tick();
      if_req = 1'b0;
      #1;
      chk("f_mem_en", mem_en, 1);
      chk("f_mem_addr", mem_addr, 32'h100);
      chk("f_mem_wdata", mem_wdata, 0);
      chk("f_mem_bsel", mem_bsel, 0);
      chk("f_mem_wr_en", mem_wr_en, 0);
      no_rvalid(2);
      tick();
      #1;
      chk("f_if_rvalid", if_rvalid, 1);
      chk("f_if_rdata", if_rdata, 32'hDEADBEEF);
      chk("f_dm_rvalid", dm_rvalid, 0);
      no_rvalid(3);

      // cycle tables
      for (int r = 0; r < vecs.size(); r++) begin
         tick();
         if_req = vecs[r].if_req; dm_req = vecs[r].dm_req;
         dm_wr_en = vecs[r].dm_wr; if_flush = vecs[r].flush;
         if_addr = 32'h1000 + 32'(r * 4);
         dm_addr = 32'h2000 + 32'(r * 4);
         dm_wdata = '0; dm_bsel = '0;
         #1;
         chk($sformatf("v%0d_if_gnt", r), if_gnt, vecs[r].e_if_gnt);
         chk($sformatf("v%0d_dm_gnt", r), dm_gnt, vecs[r].e_dm_gnt);
         chk($sformatf("v%0d_mem_en", r), mem_en,
             (r > 0) ? (vecs[r-1].e_if_gnt | vecs[r-1].e_dm_gnt) : 1'b0);
         chk($sformatf("v%0d_if_rvalid", r), if_rvalid, vecs[r].e_if_rv);
         chk($sformatf("v%0d_dm_rvalid", r), dm_rvalid, vecs[r].e_dm_rv);
         if (vecs[r].e_if_rv && r >= 4)
            chk($sformatf("v%0d_if_rdata", r), if_rdata, mem_fn(32'h1000 + 32'((r - 4) * 4)));
         if (vecs[r].e_dm_rv && r >= 4)
            chk($sformatf("v%0d_dm_rdata", r), dm_rdata, mem_fn(32'h2000 + 32'((r - 4) * 4)));
      end
      tick();
      if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0; dm_wr_en = 1'b0;
      no_rvalid(5);

      // reset mid-flight
      tick();
      if_req = 1'b1; if_addr = 32'h300;
      #1;
      chk("rm_if_gnt", if_gnt, 1);
      tick();
      if_req = 1'b0; dm_req = 1'b1; dm_addr = 32'h400;
      #1;
      chk("rm_dm_gnt", dm_gnt, 1);
      tick();
      rst = 1'b1;
      #1;
      chk("rm_dm_gnt_rst", dm_gnt, 0);
      chk("rm_mem_en", mem_en, 0);
      chk("rm_mem_addr", mem_addr, 0);
      chk("rm_if_rvalid", if_rvalid, 0);
      chk("rm_dm_rvalid", dm_rvalid, 0);
      chk("rm_if_rdata", if_rdata, 0);
      chk("rm_dm_rdata", dm_rdata, 0);
      dm_req = 1'b0;
      tick();
      rst = 1'b0;
      no_rvalid(6);
      tick();
      if_req = 1'b1; if_addr = 32'h500;
      #1;
      chk("rp_if_gnt", if_gnt, 1);
      tick();
      if_req = 1'b0;
      #1;
      chk("rp_mem_addr", mem_addr, 32'h500);
      no_rvalid(2);
      tick();
      #1;
      chk("rp_if_rvalid", if_rvalid, 1);
      chk("rp_if_rdata", if_rdata, mem_fn(32'h500));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/riscv_mem_arb.md
Name: riscv_mem_arb

Overview:
- Arbitrates one single-port unified memory between the instruction-fetch port and the data (load/store) port of the RISC-V pipeline.
- Issues at most one memory command per cycle. The memory itself is pipelined with a fixed read latency.
- Each read response is tagged with its owner and returned to the correct port.
- Fetch is protected from starvation, and in-flight fetches can be squashed by a pipeline flush on a taken branch or jump.

Parameters:
- XLEN, 32, address/data width.
- MEM_LAT, 2, cycles from memory sampling a read command to i_mem_rdata valid (legal range 1..8).
- STARVE_MAX, 4, consecutive denied fetch-request cycles after which fetch takes priority (legal range 1..15).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_if_req  in  1  fetch read request; held until granted
- i_if_addr  in  XLEN  fetch address
- i_if_flush  in  1  squash all in-flight fetches; block fetch grant this cycle
- o_if_gnt  out  1  fetch request accepted this cycle (combinational)
- o_if_rvalid  out  1  fetch read data valid (registered)
- o_if_rdata  out  XLEN  fetch read data (registered)
- i_dm_req  in  1  data request; held until granted
- i_dm_wr_en  in  1  1 = store, 0 = load
- i_dm_addr  in  XLEN  data address
- i_dm_wdata  in  XLEN  store data
- i_dm_bsel  in  4  store byte-enable mask
- o_dm_gnt  out  1  data request accepted this cycle (combinational)
- o_dm_rvalid  out  1  load data valid (registered)
- o_dm_rdata  out  XLEN  load data (registered)
- o_mem_en  out  1  memory command valid (registered)
- o_mem_wr_en  out  1  memory write (registered)
- o_mem_addr  out  XLEN  memory address (registered)
- o_mem_wdata  out  XLEN  memory write data (registered)
- o_mem_bsel  out  4  memory byte enables (registered)
- i_mem_rdata  in  XLEN  memory read data, valid MEM_LAT cycles after the command edge

Behaviour:
- Reset (async, i_rst=1):
  - All registered outputs, the starvation counter and the tag pipeline clear to 0.
  - Combinational grants evaluate to 0 while in reset.
  - Reset mid-transaction drops all in-flight responses; no rvalid is issued for them after release.
- Arbitration, per cycle, combinational:
  - starve = (starve_cnt == STARVE_MAX).
  - if_gnt = i_if_req & ~i_if_flush & (~i_dm_req | starve).
  - dm_gnt = i_dm_req & ~if_gnt.
  - At most one grant per cycle; a grant is only asserted with its request.
- Starvation counter (4-bit):
  - Clears when fetch is granted, when i_if_req=0, or when i_if_flush=1.
  - Increments when i_if_req=1 and fetch is not granted.
  - Saturates at STARVE_MAX.
- Command stage, registered at the edge ending grant cycle N, visible in N+1:
  - o_mem_en = if_gnt|dm_gnt.
  - o_mem_wr_en = dm_gnt & i_dm_wr_en.
  - addr/wdata/bsel come from the granted port; wdata and bsel are zero for fetch.
  - No grant: o_mem_en=0; addr/wdata/bsel/wr_en hold their previous values.
- Tag pipeline:
  - Shift register of depth MEM_LAT+1; each entry is {valid, owner(0=IF, 1=DM)}.
  - An entry is pushed for every read grant. Stores push valid=0 and produce no response.
  - The entry reaching the last stage aligns with i_mem_rdata in cycle N+1+MEM_LAT.
- Response stage:
  - i_mem_rdata is registered into the owner's rdata, with rvalid pulsed for 1 cycle in N+2+MEM_LAT.
  - Total read latency from grant cycle = MEM_LAT+2.
  - The non-owner rvalid is 0 and its rdata holds.
  - Responses per port return in grant order.
- Flush:
  - i_if_flush=1 in cycle K clears the valid bit of every IF-owned tag, at every stage, at the edge ending K.
  - Any fetch response whose data would register at that same edge is also suppressed, so no o_if_rvalid occurs in K+1 for it.
  - DM tags are unaffected; a data grant in cycle K proceeds normally.
- Back-to-back: one grant per cycle is sustainable indefinitely; there is no outstanding-request limit.
- Simultaneous flush and data request: data is granted, fetch is blocked.
- Unknown or absent requests: no grant; the command stage is idle.

Test Plan:
- Single fetch:
  - Stimulus: MEM_LAT=2, i_if_req=1, i_if_addr=0x100 in cycle 0, memory returns 0xDEADBEEF.
  - Required: o_if_gnt=1 in cycle 0; o_mem_en=1, o_mem_addr=0x100 in cycle 1; o_if_rvalid=1, o_if_rdata=0xDEADBEEF in cycle 4; o_dm_rvalid stays 0.
- Store:
  - Stimulus: i_dm_req=1, wr_en=1, addr=0x2000, wdata=0x12345678, bsel=0x3.
  - Required: o_dm_gnt=1; next cycle o_mem_wr_en=1 with those values; no rvalid ever on either port.
- Starvation:
  - Stimulus: i_if_req and i_dm_req (loads) both held high from cycle 0, STARVE_MAX=4.
  - Required: dm granted in cycles 0-3, if in 4, dm in 5-8, if in 9; responses on correct ports at grant+4.
- Flush:
  - Stimulus: fetches granted in cycles 0, 1, 2; i_if_flush=1 in cycle 3 with i_if_req=1.
  - Required: o_if_gnt=0 in cycle 3; o_if_rvalid is 0 in cycles 4-6; a load granted in cycle 3 still returns in cycle 7.
- Interleaved ordering:
  - Stimulus: alternating IF/DM load grants over 6 cycles with distinct i_mem_rdata values.
  - Required: each value appears on the correct port exactly MEM_LAT+2 cycles after its grant.
- Reset mid-flight:
  - Stimulus: assert i_rst in cycle 2 after reads granted in cycles 0-1.
  - Required: all outputs 0 immediately (asynchronously); no rvalid after release; a new fetch after release completes with normal latency.
